// File: rtl/axis_window_expander_pkg.sv
// Shared types and helpers for the window expander.
// State encoding and a width-generic saturating increment.
package axis_window_expander_pkg;

  localparam int          CNTR_W = 32;
  localparam int unsigned SAT_W  = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // w is the live width of v; bits above w are zero on entry.
  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] v,
    input int unsigned      w
  );
    logic [SAT_W-1:0] top;
    top = (w >= SAT_W) ? '1 : ((64'd1 << w) - 64'd1);
    return (v == top) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/axis_window_expander_fifo2.sv
// Two-entry register FIFO, head always in slot 0.
// The not-full flag is registered so ready never depends on pop.
module axis_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         not_full_o
);

  logic [W-1:0] m0_q, m0_d;
  logic [W-1:0] m1_q, m1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         nf_q, nf_d;

  always_comb begin
    m0_d  = m0_q;
    m1_d  = m1_q;
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) m0_d = din_i;
        else               m1_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        m0_d  = m1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          m0_d = din_i;
        end else begin
          m0_d = m1_q;
          m1_d = din_i;
        end
      end
      default: ;
    endcase
    nf_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_q  <= '0;
      m1_q  <= '0;
      cnt_q <= 2'd0;
      nf_q  <= 1'b0;
    end else begin
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      cnt_q <= cnt_d;
      nf_q  <= nf_d;
    end
  end

  assign dout_o     = m0_q;
  assign empty_o    = (cnt_q == 2'd0);
  assign not_full_o = nf_q;

endmodule

// File: rtl/axis_window_expander.sv
// Repeats each accepted value for cfg_data+1 beats with tlast per window.
// On input underflow the last value is re-sent and counted.
module axis_window_expander
  import axis_window_expander_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int CNTR_WIDTH       = CNTR_W
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  output logic [CNTR_WIDTH-1:0]       sts_data,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  state_e                      state_q, state_d;
  logic [AXIS_TDATA_WIDTH-1:0] cur_q, cur_d;
  logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]       len_q, len_d;
  logic [CNTR_WIDTH-1:0]       sts_q, sts_d;

  logic                        push, pop;
  logic                        empty, not_full;
  logic [AXIS_TDATA_WIDTH-1:0] head;
  logic                        last, hs;

  axis_fifo2 #(
    .W (AXIS_TDATA_WIDTH)
  ) u_fifo (
    .clk        (aclk),
    .rst        (areset),
    .push_i     (push),
    .din_i      (s_axis_tdata),
    .pop_i      (pop),
    .dout_o     (head),
    .empty_o    (empty),
    .not_full_o (not_full)
  );

  assign push = s_axis_tvalid & not_full;
  assign last = (state_q == RUN) && (cnt_q == len_q);
  assign hs   = (state_q == RUN) && m_axis_tready;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sts_d   = sts_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_d   = head;
          cnt_d   = '0;
          len_d   = cfg_data;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs && last) begin
          cnt_d = '0;
          len_d = cfg_data;
          if (!empty) begin
            pop   = 1'b1;
            cur_d = head;
          end else begin
            // Underflow: keep repeating cur, count the missed window.
            sts_d = CNTR_WIDTH'(sat_inc(SAT_W'(sts_q),
                                        unsigned'(CNTR_WIDTH)));
          end
        end else if (hs) begin
          cnt_d = cnt_q + CNTR_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sts_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sts_q   <= sts_d;
    end
  end

  assign s_axis_tready = not_full;
  assign m_axis_tvalid = (state_q == RUN);
  assign m_axis_tdata  = cur_q;
  assign m_axis_tlast  = last;
  assign sts_data      = sts_q;

endmodule

// File: tb/tb_axis_window_expander.sv
// Directed bench for axis_window_expander: cycle table plus
// multi-cycle sequences (backpressure, full rate, fifo full, cfg, reset).
module tb_axis_window_expander;

  localparam int DW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          areset;
  logic [CW-1:0] cfg;
  logic [CW-1:0] sts;
  logic          s_ready, s_valid;
  logic [DW-1:0] s_data;
  logic          m_ready, m_valid, m_last;
  logic [DW-1:0] m_data;

  logic [1:0]    s2_cfg, s2_sts;
  logic          s2_sready, s2_svalid;
  logic [DW-1:0] s2_sdata, s2_mdata;
  logic          s2_mready, s2_mvalid, s2_mlast;

  always #5 clk = ~clk;

  axis_window_expander #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
    .aclk(clk), .areset(areset), .cfg_data(cfg), .sts_data(sts),
    .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tvalid(s_valid), .m_axis_tready(m_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid),
    .m_axis_tlast(m_last)
  );

  axis_window_expander #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(2)) sat (
    .aclk(clk), .areset(areset), .cfg_data(s2_cfg), .sts_data(s2_sts),
    .s_axis_tready(s2_sready), .s_axis_tdata(s2_sdata),
    .s_axis_tvalid(s2_svalid), .m_axis_tready(s2_mready),
    .m_axis_tdata(s2_mdata), .m_axis_tvalid(s2_mvalid),
    .m_axis_tlast(s2_mlast)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pushed = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [CW-1:0] s;
  } beat_t;
  beat_t q[$];

  logic          mon_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;

  always @(negedge clk) begin
    if (areset) begin
      prev_stall <= 1'b0;
    end else begin
      if (mon_en && prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", 64'(m_data), 64'(prev_d));
        check("stall_last", 64'(m_last), 64'(prev_l));
      end
      if (mon_en && m_valid && m_ready)
        q.push_back('{m_data, m_last, sts});
      prev_stall <= m_valid & ~m_ready;
      prev_d     <= m_data;
      prev_l     <= m_last;
    end
  end

  task automatic do_reset();
    areset    = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
    s2_svalid = 1'b0;
    s2_sdata  = '0;
    s2_mready = 1'b0;
    s2_cfg    = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
  endtask

  task automatic push(input logic [DW-1:0] v, output int cyc);
    logic got;
    got     = 1'b0;
    cyc     = 0;
    s_valid = 1'b1;
    s_data  = v;
    while (!got && cyc < 300) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("push_accepted", 64'(got), 64'd1);
    s_valid = 1'b0;
    n_pushed++;
  endtask

  task automatic wait_beats(input string nm, input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({nm, "_beats"}, 64'(q.size() >= n), 64'd1);
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic [CW-1:0] ests;
  } vec_t;
  vec_t vt[15];

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [DW-1:0] ed;
    // basic repeat, cfg=3: inputs and outputs per cycle
    vt[0]  = '{1, 16'd10, 0, 16'd0,  0, 0};
    vt[1]  = '{1, 16'd20, 0, 16'd0,  0, 0};
    vt[2]  = '{0, 16'd0,  1, 16'd10, 0, 0};
    vt[3]  = '{0, 16'd0,  1, 16'd10, 0, 0};
    vt[4]  = '{0, 16'd0,  1, 16'd10, 0, 0};
    vt[5]  = '{0, 16'd0,  1, 16'd10, 1, 0};
    vt[6]  = '{0, 16'd0,  1, 16'd20, 0, 0};
    vt[7]  = '{0, 16'd0,  1, 16'd20, 0, 0};
    vt[8]  = '{0, 16'd0,  1, 16'd20, 0, 0};
    vt[9]  = '{0, 16'd0,  1, 16'd20, 1, 0};
    vt[10] = '{0, 16'd0,  1, 16'd20, 0, 1};
    vt[11] = '{0, 16'd0,  1, 16'd20, 0, 1};
    vt[12] = '{0, 16'd0,  1, 16'd20, 0, 1};
    vt[13] = '{0, 16'd0,  1, 16'd20, 1, 1};
    vt[14] = '{0, 16'd0,  1, 16'd20, 0, 2};

    cfg     = 32'd3;
    areset  = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    #1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_sts", 64'(sts), 64'd0);

    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      s_valid = vt[i].sv;
      s_data  = vt[i].sd;
      @(negedge clk);
      check($sformatf("basic%0d_valid", i), 64'(m_valid), 64'(vt[i].ev));
      check($sformatf("basic%0d_data", i), 64'(m_data), 64'(vt[i].ed));
      check($sformatf("basic%0d_last", i), 64'(m_last), 64'(vt[i].el));
      check($sformatf("basic%0d_sready", i), 64'(s_ready), 64'd1);
      check($sformatf("basic%0d_sts", i), 64'(sts), 64'(vt[i].ests));
      @(posedge clk);
      #1;
    end

    // backpressure, cfg=2, random m_ready
    do_reset();
    cfg    = 32'd2;
    mon_en = 1'b1;
    fork
      begin
        for (int j = 0; j < 6; j++) push(16'(100 + j), cyc);
      end
      begin
        for (int k = 0; k < 400 && q.size() < 18; k++) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    m_ready = 1'b1;
    wait_beats("bp", 18);
    for (int i = 0; i < 18 && i < q.size(); i++) begin
      check($sformatf("bp%0d_data", i), 64'(q[i].d), 64'(100 + i / 3));
      check($sformatf("bp%0d_last", i), 64'(q[i].l), 64'(i % 3 == 2));
    end

    // full rate, cfg=0
    do_reset();
    cfg     = 32'd0;
    m_ready = 1'b1;
    for (int v = 1; v <= 100; v++) begin
      push(16'(v), cyc);
      check($sformatf("fr%0d_no_bubble", v), 64'(cyc), 64'd1);
    end
    wait_beats("fr", 100);
    for (int i = 0; i < 100 && i < q.size(); i++) begin
      check($sformatf("fr%0d_data", i), 64'(q[i].d), 64'(i + 1));
      check($sformatf("fr%0d_last", i), 64'(q[i].l), 64'd1);
    end
    if (q.size() >= 100) check("fr_sts", 64'(q[99].s), 64'd0);

    // fifo full with output stalled
    do_reset();
    cfg      = 32'd0;
    m_ready  = 1'b0;
    n_pushed = 0;
    fork
      begin
        push(16'd5, cyc);
        push(16'd6, cyc);
        push(16'd7, cyc);
        push(16'd8, cyc);
      end
    join_none
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("full_accepted", 64'(n_pushed), 64'd3);
    check("full_s_ready", 64'(s_ready), 64'd0);
    check("full_cur_valid", 64'(m_valid), 64'd1);
    check("full_cur_data", 64'(m_data), 64'd5);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_beats("full", 4);
    for (int i = 0; i < 4 && i < q.size(); i++)
      check($sformatf("full%0d_data", i), 64'(q[i].d), 64'(5 + i));
    for (int k = 0; k < 50 && n_pushed < 4; k++) @(posedge clk);
    check("full_all_pushed", 64'(n_pushed), 64'd4);
    #1;

    // cfg change mid-window
    do_reset();
    cfg     = 32'd3;
    m_ready = 1'b1;
    push(16'd7, cyc);
    push(16'd9, cyc);
    wait_beats("cfg_a", 2);
    cfg = 32'd1;
    wait_beats("cfg_b", 8);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      ed = (i < 4) ? 16'd7 : 16'd9;
      check($sformatf("cfg%0d_data", i), 64'(q[i].d), 64'(ed));
      check($sformatf("cfg%0d_last", i), 64'(q[i].l),
            64'(i == 3 || i == 5 || i == 7));
    end

    // async reset mid-window
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_sts_nonzero", 64'(sts != 0), 64'd1);
    check("pre_rst_valid", 64'(m_valid), 64'd1);
    @(posedge clk);
    #3;
    areset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_sts", 64'(sts), 64'd0);
    check("mid_rst_last", 64'(m_last), 64'd0);
    check("mid_rst_data", 64'(m_data), 64'd0);
    check("mid_rst_sready", 64'(s_ready), 64'd0);
    mon_en = 1'b0;

    // saturation on a 2-bit counter instance
    do_reset();
    s2_cfg    = 2'd0;
    s2_mready = 1'b1;
    s2_svalid = 1'b1;
    s2_sdata  = 16'h0055;
    @(posedge clk);
    #1;
    s2_svalid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("sat_first", 64'(s2_sts), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check("sat_hold", 64'(s2_sts), 64'd3);
    check("sat_data", 64'(s2_mdata), 64'h55);
    check("sat_valid", 64'(s2_mvalid), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("sat_hold2", 64'(s2_sts), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_window_expander.md
# axis_window_expander

Inverse of the per-window max-abs reduction: accepts one AXI4-Stream value per window and re-expands it to a full-rate stream. Each accepted value is repeated for exactly cfg_data+1 output beats, with m_axis_tlast marking the last beat of every window. The block sits downstream of window-reduction cores (peak/envelope finders) and drives sample-rate consumers such as DAC gain/envelope paths. When the input runs dry it holds the last value and counts underflows.

## Interface
- AXIS_TDATA_WIDTH, 16, data width of input and output streams
- CNTR_WIDTH, 32, width of the window-length config and the underflow counter

- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- cfg_data  in  CNTR_WIDTH  window length minus one (window = cfg_data+1 beats)
- sts_data  out  CNTR_WIDTH  saturating underflow count
- s_axis_tready  out  1  input ready (registered)
- s_axis_tdata  in  AXIS_TDATA_WIDTH  value for one window
- s_axis_tvalid  in  1  input valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  AXIS_TDATA_WIDTH  expanded sample
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  high on final beat of each window

## Operation
- Input path: 2-entry FIFO. s_axis_tready = ~full, registered, no combinational path from m_axis_tready. A push occurs on s_axis_tvalid & s_axis_tready.
- Output registers: cur (value being repeated), beat counter cnt, latched window length len.
- States:
  - IDLE: m_axis_tvalid=0. If the FIFO is non-empty: pop into cur, cnt←0, len←cfg_data, go to RUN.
  - RUN: m_axis_tvalid=1 and m_axis_tdata=cur. On each output handshake (m_axis_tvalid & m_axis_tready), cnt←cnt+1.
- m_axis_tlast = (cnt == len), combinational from registers only.
- Window end (handshake with cnt == len):
  - cnt←0 and len←cfg_data.
  - If the FIFO is non-empty, pop into cur.
  - If the FIFO is empty, keep cur and sts_data←sts_data+1, saturating at all-ones. The state stays RUN and never returns to IDLE except by reset.
- cfg_data is sampled only at window start. A mid-window change takes effect in the next window.
- Simultaneous push and pop in one cycle: the FIFO count is unchanged, and the FIFO stays correct when full.
- Width rules: cnt and len are CNTR_WIDTH unsigned. cnt never exceeds len, so there is no wrap.

## Timing
- Reset values: s_axis_tready=0 during reset and 1 from the first cycle after release; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; sts_data=0; FIFO empty; state IDLE.
- Asserting areset mid-window clears all state immediately. The in-flight window is discarded.
- Latency: first input handshake at cycle t gives m_axis_tvalid=1 at cycle t+2.
- AXIS rules: m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid & ~m_axis_tready. m_axis_tvalid never drops without a handshake once in RUN.
- Throughput: one output beat per cycle when m_axis_tready=1. With cfg_data=0, one input per cycle is sustained with no bubbles.
- The FIFO is full after 3 accepted values (1 in cur, 2 queued) with no output handshakes.

## Structure
- Single module plus one sub-module: axis_fifo2, a 2-entry register FIFO with a registered not-full output.
- Shared package (or header) holds:
  - the state encoding constants IDLE and RUN;
  - a saturating-increment helper function for CNTR_WIDTH.

## Test plan
- Basic repeat: cfg_data=3, push 10 then 20, m_axis_tready=1. Expect 10,10,10,10 with tlast on beat 4, then 20×4, then 20×4 again with sts_data=1.
- Backpressure: cfg_data=2 with random m_axis_tready. Expect tdata/tlast stable while stalled, exactly 3 beats per value, and no lost or duplicated windows.
- Full rate: cfg_data=0, push 1,2,3,…,100 every cycle, m_axis_tready=1. Expect the output equals the input 1:1, tlast on every beat, s_axis_tready held high after the first cycle, and sts_data=0.
- FIFO full: m_axis_tready=0, push 5,6,7,8. Expect 5,6,7 accepted and s_axis_tready=0 while 8 is pending. After releasing m_axis_tready, 8 is accepted and the order is 5,6,7,8.
- Config change: cfg_data=3; change it to 1 after 2 beats of the first window. Expect the first window to be 4 beats and the next windows to be 2 beats.
- Reset/saturation: assert areset mid-window. Expect m_axis_tvalid=0 and sts_data=0 in the same cycle. Separately, force the counter near max and confirm sts_data holds at all-ones after further underflows.
